online_mult_ctrl: RTL and testbench
===================================

ONLINE_MULT_CTRL -- requirements
Module: online_mult_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 4, meaning operand length in signed digits.
REQ-002 The block SHALL have parameter DELTA, default 2, meaning online delay in cycles, legal range 1..NUM_BITS-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin one multiplication.
REQ-006 The block SHALL have port hold, input, 1 bit: stall request; freezes sequencing while high.
REQ-007 The block SHALL have port abort, input, 1 bit: cancel the operation in progress.
REQ-008 The block SHALL have ports x_plus and x_minus, input, NUM_BITS each: borrow-save X operand, sampled on start acceptance.
REQ-009 The block SHALL have ports y_plus and y_minus, input, NUM_BITS each: borrow-save Y operand, sampled on start acceptance.
REQ-010 The block SHALL have port state, output, 2 bits: phase code, 00 IDLE, 01 INIT, 10 COMPUTE, 11 FLUSH.
REQ-011 The block SHALL have ports x_digit_sel and y_digit_sel, output, 2 bits each: current digit to the vector multipliers; 10 = +1, 01 = -1, 00 = 0.
REQ-012 The block SHALL have port sdvm_we, output, 1 bit: write enable to the digit-select registers of the vector multipliers.
REQ-013 The block SHALL have port out_valid, output, 1 bit: a product digit is valid this cycle.
REQ-014 The block SHALL have ports busy (1 bit), done (1 bit, one-cycle pulse) and digit_idx (clog2(NUM_BITS+DELTA+1) bits), all outputs.

Function
REQ-015 In IDLE, start=1 SHALL be accepted: both operands are latched and the block enters INIT on the next edge.
REQ-016 Step counter k SHALL start at 0 on acceptance and increment by 1 on each busy cycle with hold=0; digit_idx SHALL equal k.
REQ-017 Phase sequencing SHALL be: INIT for k < DELTA; COMPUTE for DELTA <= k < NUM_BITS; FLUSH for NUM_BITS <= k < NUM_BITS+DELTA.
REQ-018 After the step at k = NUM_BITS+DELTA-1 completes, the block SHALL return to IDLE and assert done for exactly one cycle.
REQ-019 For k < NUM_BITS, each digit_sel SHALL encode operand bit position NUM_BITS-1-k (MSD first); for k >= NUM_BITS it SHALL be 00.
REQ-020 Digit encoding SHALL be: plus=1, minus=0 -> 10; plus=0, minus=1 -> 01; equal bits -> 00.
REQ-021 sdvm_we SHALL equal busy AND NOT hold; out_valid SHALL equal (k >= DELTA) AND busy AND NOT hold.
REQ-022 While hold=1, k, the phase and the latched operands SHALL be frozen, and digit_sel outputs SHALL keep their values.
REQ-023 start SHALL be ignored while busy; the latched operands SHALL NOT change.
REQ-024 abort=1 while busy SHALL return the block to IDLE on the next edge, with no done pulse and digit_sel outputs forced to 00.
REQ-025 abort SHALL take priority over hold; abort in IDLE SHALL have no effect; start together with abort in IDLE SHALL be accepted.
REQ-026 In IDLE, outputs SHALL be: busy=0, sdvm_we=0, out_valid=0, digit_sel=00, and digit_idx SHALL hold 0.
REQ-027 A start sampled in the same cycle as done SHALL be accepted, because the block is already in IDLE.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state=00, k=0, operand registers=0, digit_sel=00, sdvm_we=0, out_valid=0, busy=0, done=0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation without a done pulse; the first start after reset release SHALL begin from k=0.

Structure
REQ-030 The phase codes and digit encodings (DIG_POS=10, DIG_NEG=01, DIG_ZERO=00) SHALL be defined in the shared package online_mult_pkg.
REQ-031 The borrow-save bit-pair to digit encoder SHALL be one sub-module, sd_digit_enc, instantiated once per operand.
REQ-032 Phase, counter and operand registers SHALL be the only state; all outputs SHALL be decoded from them.

Verification
REQ-033 With x=(1010,0101), y=(1100,0000) and start pulsed: x_digit_sel SHALL be 10,01,10,01,00,00; y_digit_sel SHALL be 10,10,00,00,00,00; state SHALL be 01,01,10,10,11,11; done SHALL pulse at cycle 7.
REQ-034 With hold=1 for 3 cycles at k=2: state, digit_idx and digit_sel SHALL freeze and sdvm_we/out_valid SHALL be 0; done SHALL be delayed by exactly 3 cycles.
REQ-035 With abort at k=3: the next cycle SHALL show state=00, digit_sel=00, and no done pulse.
REQ-036 With start re-pulsed at k=1 carrying different operands: the digit stream SHALL be unchanged from the first operands.
REQ-037 With rst_n low at k=4 and then start after release: outputs SHALL be zero immediately, and the new run SHALL restart at k=0.
REQ-038 With start held high continuously: back-to-back runs SHALL occur with exactly one IDLE cycle (the done cycle) between them.

Source files
------------

// File: rtl/online_mult_pkg.sv
// Shared phase codes, signed-digit encodings and phase decode
// for the online multiplier controller.
package online_mult_pkg;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'b00,
    PH_INIT    = 2'b01,
    PH_COMPUTE = 2'b10,
    PH_FLUSH   = 2'b11
  } phase_e;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  // Phase that owns step k of an n-digit, d-delay run.
  function automatic phase_e phase_of(
    input int k,
    input int n,
    input int d
  );
    if (k < d)      return PH_INIT;
    else if (k < n) return PH_COMPUTE;
    else            return PH_FLUSH;
  endfunction

endpackage

// File: rtl/online_mult_ctrl_enc.sv
// Borrow-save bit pair to signed-digit select code.
// Disabled or equal bits give the zero digit.
module sd_digit_enc
  import online_mult_pkg::*;
(
  input  logic       i_en,
  input  logic       i_plus,
  input  logic       i_minus,
  output logic [1:0] o_dig
);

  always_comb begin
    o_dig = DIG_ZERO;
    unique case (1'b1)
      (i_en &&  i_plus && !i_minus): o_dig = DIG_POS;
      (i_en && !i_plus &&  i_minus): o_dig = DIG_NEG;
      default:                       o_dig = DIG_ZERO;
    endcase
  end

endmodule

// File: rtl/online_mult_ctrl.sv
// Online multiplier sequencer: steps MSD-first through both
// borrow-save operands, then flushes the online delay.
module online_mult_ctrl
  import online_mult_pkg::*;
#(
  parameter int NUM_BITS = 4,
  parameter int DELTA    = 2,
  localparam int KW      = $clog2(NUM_BITS + DELTA + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                hold,
  input  logic                abort,
  input  logic [NUM_BITS-1:0] x_plus,
  input  logic [NUM_BITS-1:0] x_minus,
  input  logic [NUM_BITS-1:0] y_plus,
  input  logic [NUM_BITS-1:0] y_minus,
  output logic [1:0]          state,
  output logic [1:0]          x_digit_sel,
  output logic [1:0]          y_digit_sel,
  output logic                sdvm_we,
  output logic                out_valid,
  output logic                busy,
  output logic                done,
  output logic [KW-1:0]       digit_idx
);

  localparam logic [KW-1:0] K_N    = KW'(NUM_BITS);
  localparam logic [KW-1:0] K_D    = KW'(DELTA);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_BITS + DELTA - 1);
  localparam logic [KW-1:0] K_END  = KW'(NUM_BITS + DELTA);

  phase_e              r_phase;
  logic [KW-1:0]       r_k;
  logic [NUM_BITS-1:0] r_xp;
  logic [NUM_BITS-1:0] r_xm;
  logic [NUM_BITS-1:0] r_yp;
  logic [NUM_BITS-1:0] r_ym;

  logic          w_busy;
  logic          w_last;
  logic          w_dig_en;
  logic [KW-1:0] w_k_nxt;
  logic          w_xp_bit;
  logic          w_xm_bit;
  logic          w_yp_bit;
  logic          w_ym_bit;

  assign w_busy   = (r_phase != PH_IDLE);
  assign w_last   = (r_k == K_LAST);
  assign w_k_nxt  = r_k + KW'(1);
  assign w_dig_en = w_busy && (r_k < K_N);

  // Step k reads operand bit NUM_BITS-1-k.
  always_comb begin
    w_xp_bit = 1'b0;
    w_xm_bit = 1'b0;
    w_yp_bit = 1'b0;
    w_ym_bit = 1'b0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (r_k == KW'(NUM_BITS - 1 - i)) begin
        w_xp_bit = r_xp[i];
        w_xm_bit = r_xm[i];
        w_yp_bit = r_yp[i];
        w_ym_bit = r_ym[i];
      end
    end
  end

  // k parks at K_END for the single done cycle after a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_IDLE;
      r_k     <= '0;
      r_xp    <= '0;
      r_xm    <= '0;
      r_yp    <= '0;
      r_ym    <= '0;
    end else if (r_phase == PH_IDLE) begin
      r_k <= '0;
      if (start) begin
        r_phase <= phase_of(0, NUM_BITS, DELTA);
        r_xp    <= x_plus;
        r_xm    <= x_minus;
        r_yp    <= y_plus;
        r_ym    <= y_minus;
      end
    end else if (abort) begin
      r_phase <= PH_IDLE;
      r_k     <= '0;
    end else if (!hold) begin
      if (w_last) begin
        r_phase <= PH_IDLE;
        r_k     <= K_END;
      end else begin
        r_phase <= phase_of(int'(w_k_nxt), NUM_BITS, DELTA);
        r_k     <= w_k_nxt;
      end
    end
  end

  sd_digit_enc u_x_enc (
    .i_en    (w_dig_en),
    .i_plus  (w_xp_bit),
    .i_minus (w_xm_bit),
    .o_dig   (x_digit_sel)
  );

  sd_digit_enc u_y_enc (
    .i_en    (w_dig_en),
    .i_plus  (w_yp_bit),
    .i_minus (w_ym_bit),
    .o_dig   (y_digit_sel)
  );

  assign state     = r_phase;
  assign busy      = w_busy;
  assign sdvm_we   = w_busy && !hold;
  assign out_valid = w_busy && !hold && (r_k >= K_D);
  assign done      = (r_phase == PH_IDLE) && (r_k == K_END);
  assign digit_idx = w_busy ? r_k : '0;

endmodule

// File: tb/tb_online_mult_ctrl.sv
// Directed bench for online_mult_ctrl at NUM_BITS=4, DELTA=2.
// Expected streams are hand-derived from the operand bit pairs.
module tb_online_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] x_plus = '0;
  logic [3:0] x_minus = '0;
  logic [3:0] y_plus = '0;
  logic [3:0] y_minus = '0;
  logic [1:0] state;
  logic [1:0] x_digit_sel;
  logic [1:0] y_digit_sel;
  logic       sdvm_we;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic [2:0] digit_idx;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] exp_x [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
  logic [1:0] exp_y [6] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] exp_st[6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};

  online_mult_ctrl #(.NUM_BITS(4), .DELTA(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .hold        (hold),
    .abort       (abort),
    .x_plus      (x_plus),
    .x_minus     (x_minus),
    .y_plus      (y_plus),
    .y_minus     (y_minus),
    .state       (state),
    .x_digit_sel (x_digit_sel),
    .y_digit_sel (y_digit_sel),
    .sdvm_we     (sdvm_we),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done),
    .digit_idx   (digit_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [3:0] xp, xm, yp, ym);
    x_plus  = xp;
    x_minus = xm;
    y_plus  = yp;
    y_minus = ym;
  endtask

  function automatic logic [12:0] snap();
    return {state, x_digit_sel, y_digit_sel, digit_idx,
            busy, sdvm_we, out_valid, done};
  endfunction

  task automatic test_reset();
    logic [12:0] got;
    rst_n = 1'b0;
    start = 1'b1;
    #2;
    got = snap();
    vectors++;
    if (got !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_async got=%b exp=%b", got, 13'd0);
    end
    step();
    got = snap();
    vectors++;
    if (got !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_start got=%b exp=%b", got, 13'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_idle_abort();
    logic [12:0] got;
    abort = 1'b1;
    step();
    abort = 1'b0;
    got = snap();
    vectors++;
    if (got !== 13'd0) begin
      miscompares++;
      $display("FAIL idle_abort got=%b exp=%b", got, 13'd0);
    end
  endtask

  task automatic test_basic();
    logic [12:0] got;
    logic [12:0] e;
    set_ops(4'b1010, 4'b0101, 4'b1100, 4'b0000);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int p = 0; p < 6; p++) begin
      e = {exp_st[p], exp_x[p], exp_y[p], 3'(p),
           1'b1, 1'b1, (p >= 2), 1'b0};
      got = snap();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL basic k=%0d got=%b exp=%b", p, got, e);
      end
      step();
    end
    got = snap();
    vectors++;
    if (got !== 13'b0000000000001) begin
      miscompares++;
      $display("FAIL basic_done got=%b exp=%b", got, 13'b1);
    end
    step();
    got = snap();
    vectors++;
    if (got !== 13'd0) begin
      miscompares++;
      $display("FAIL basic_after got=%b exp=%b", got, 13'd0);
    end
  endtask

  task automatic test_hold();
    logic [12:0] got;
    logic [12:0] e;
    int cnt;
    set_ops(4'b1010, 4'b0101, 4'b1100, 4'b0000);
    start = 1'b1;
    step();
    start = 1'b0;
    cnt = 1;
    e = {2'b10, 2'b10, 2'b00, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    while (done !== 1'b1 && cnt < 30) begin
      hold = (cnt >= 3 && cnt <= 5);
      #1;
      if (hold) begin
        got = snap();
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL hold c=%0d got=%b exp=%b", cnt, got, e);
        end
      end
      step();
      cnt++;
    end
    hold = 1'b0;
    vectors++;
    if (cnt !== 10 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_done cycle got=%0d exp=10", cnt);
    end
    step();
  endtask

  task automatic test_abort();
    logic [12:0] got;
    set_ops(4'b1010, 4'b0101, 4'b1100, 4'b0000);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    vectors++;
    if (digit_idx !== 3'd3 || state !== 2'b10) begin
      miscompares++;
      $display("FAIL abort_pre idx=%0d st=%b exp 3/10", digit_idx, state);
    end
    hold  = 1'b1;
    abort = 1'b1;
    step();
    hold  = 1'b0;
    abort = 1'b0;
    got = snap();
    vectors++;
    if (got !== 13'd0) begin
      miscompares++;
      $display("FAIL abort_next got=%b exp=%b", got, 13'd0);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      vectors++;
      if (done !== 1'b0 || state !== 2'b00) begin
        miscompares++;
        $display("FAIL abort_quiet c=%0d done=%b st=%b exp 0/00",
                 c, done, state);
      end
    end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    vectors++;
    if (state !== 2'b01 || digit_idx !== 3'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_abort st=%b idx=%0d busy=%b exp 01/0/1",
               state, digit_idx, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++;
    if (state !== 2'b00 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_clean st=%b done=%b exp 00/0", state, done);
    end
  endtask

  task automatic test_restart();
    logic [12:0] got;
    logic [12:0] e;
    set_ops(4'b1010, 4'b0101, 4'b1100, 4'b0000);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int p = 0; p < 6; p++) begin
      if (p == 1) begin
        start = 1'b1;
        set_ops(4'b0101, 4'b1010, 4'b0011, 4'b1100);
      end else begin
        start = 1'b0;
      end
      e = {exp_st[p], exp_x[p], exp_y[p], 3'(p),
           1'b1, 1'b1, (p >= 2), 1'b0};
      got = snap();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL restart k=%0d got=%b exp=%b", p, got, e);
      end
      step();
    end
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || state !== 2'b00) begin
      miscompares++;
      $display("FAIL restart_done done=%b st=%b exp 1/00", done, state);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [12:0] got;
    int cnt;
    set_ops(4'b1010, 4'b0101, 4'b1100, 4'b0000);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 4; c++) step();
    vectors++;
    if (digit_idx !== 3'd4 || state !== 2'b11) begin
      miscompares++;
      $display("FAIL rmid_pre idx=%0d st=%b exp 4/11", digit_idx, state);
    end
    rst_n = 1'b0;
    #1;
    got = snap();
    vectors++;
    if (got !== 13'd0) begin
      miscompares++;
      $display("FAIL rmid_async got=%b exp=%b", got, 13'd0);
    end
    #2;
    rst_n = 1'b1;
    set_ops(4'b0101, 4'b1010, 4'b0011, 4'b0000);
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if ({state, digit_idx, x_digit_sel, y_digit_sel}
        !== {2'b01, 3'd0, 2'b01, 2'b00}) begin
      miscompares++;
      $display("FAIL rmid_restart st=%b idx=%0d x=%b y=%b exp 01/0/01/00",
               state, digit_idx, x_digit_sel, y_digit_sel);
    end
    cnt = 1;
    while (done !== 1'b1 && cnt < 30) begin
      step();
      cnt++;
    end
    vectors++;
    if (cnt !== 7) begin
      miscompares++;
      $display("FAIL rmid_done cycle got=%0d exp=7", cnt);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [12:0] got;
    logic [12:0] e;
    int p;
    set_ops(4'b1010, 4'b0101, 4'b1100, 4'b0000);
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 14) start = 1'b0;
      p = (c - 1) % 7;
      if (p == 6) e = 13'b0000000000001;
      else e = {exp_st[p], exp_x[p], exp_y[p], 3'(p),
                1'b1, 1'b1, (p >= 2), 1'b0};
      got = snap();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL b2b c=%0d got=%b exp=%b", c, got, e);
      end
    end
    step();
    vectors++;
    if (state !== 2'b00 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end st=%b done=%b exp 00/0", state, done);
    end
  endtask

  initial begin
    test_reset();
    test_idle_abort();
    test_basic();
    test_hold();
    test_abort();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
